// File: rtl/lane_deskew.sv
// lane_deskew
//   Re-aligns two parallel lanes that carry the same stream with a fixed but
//   unknown relative delay. The skew is measured from the marker flags: the
//   first lane to show a marker is the leading lane, and the cycles until the
//   other lane shows its marker give the skew. After lock, the leading lane is
//   read back from its history so both lanes leave cycle-aligned, one
//   register stage after the lagging lane's input.
//
// Parameters
//   WIDTH   data width of each lane
//   MAXDLY  largest skew that can be absorbed (>= 1); history depth per lane
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   a_dat/a_mrk         lane A word and marker (valid every cycle)
//   b_dat/b_mrk         lane B word and marker (valid every cycle)
//   out_vld             aligned output valid (locked)
//   out_a/out_b/out_mrk aligned lane words, marker = both aligned markers set
//   skew, lead_b        measured skew and which lane leads (1 = lane B)
//   err                 sticky error, cleared only by rst
//
// Optional feature (macro LANE_DESKEW_STATS_EN)
//   lock_cnt, relock_cnt  saturating 8-bit counts of entries into lock and of
//                         error exits from lock
module lane_deskew #(
  parameter int WIDTH  = 8,
  parameter int MAXDLY = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             a_dat,
  input  logic                         a_mrk,
  input  logic [WIDTH-1:0]             b_dat,
  input  logic                         b_mrk,
  output logic                         out_vld,
  output logic [WIDTH-1:0]             out_a,
  output logic [WIDTH-1:0]             out_b,
  output logic                         out_mrk,
  output logic [$clog2(MAXDLY+1)-1:0]  skew,
  output logic                         lead_b,
  output logic                         err
`ifdef LANE_DESKEW_STATS_EN
  ,
  output logic [7:0]                   lock_cnt,
  output logic [7:0]                   relock_cnt
`endif
);

  localparam int SKW_W = $clog2(MAXDLY + 1);

  typedef enum logic [1:0] {SEARCH, COUNT, LOCKED} state_t;

  state_t                         state_q, state_d;
  logic [SKW_W-1:0]               cnt_q, cnt_d;
  logic [SKW_W-1:0]               skew_q, skew_d;
  logic                           lead_b_q, lead_b_d;
  logic                           err_q, err_d;
  logic                           out_vld_q, out_vld_d;
  logic                           out_mrk_q, out_mrk_d;
  logic [WIDTH-1:0]               out_a_q, out_a_d;
  logic [WIDTH-1:0]               out_b_q, out_b_d;
  logic [MAXDLY-1:0][WIDTH-1:0]   hist_a_q, hist_a_d;
  logic [MAXDLY-1:0][WIDTH-1:0]   hist_b_q, hist_b_d;
  logic [MAXDLY-1:0]              hist_am_q, hist_am_d;
  logic [MAXDLY-1:0]              hist_bm_q, hist_bm_d;
`ifdef LANE_DESKEW_STATS_EN
  logic [7:0]                     lock_cnt_q, lock_cnt_d;
  logic [7:0]                     relock_cnt_q, relock_cnt_d;
`endif

  logic [SKW_W-1:0]               sel_skew;
  logic [WIDTH-1:0]               al_a, al_b;
  logic                           al_am, al_bm;
  logic                           lag_mrk, lead_mrk;
  logic                           lock_now, relock_now;

  // Word delayed by s cycles: s = 0 is the live input, s = k is hist[k-1].
  function automatic logic [WIDTH-1:0] pick_word(
    input logic [MAXDLY-1:0][WIDTH-1:0] h,
    input logic [WIDTH-1:0]             live,
    input logic [SKW_W-1:0]             s
  );
    pick_word = live;
    for (int i = 0; i < MAXDLY; i++) begin
      if (int'(s) == i + 1) pick_word = h[i];
    end
  endfunction

  function automatic logic pick_bit(
    input logic [MAXDLY-1:0] h,
    input logic              live,
    input logic [SKW_W-1:0]  s
  );
    pick_bit = live;
    for (int i = 0; i < MAXDLY; i++) begin
      if (int'(s) == i + 1) pick_bit = h[i];
    end
  endfunction

  always_comb begin
    // History shift: index 0 is last cycle's input.
    hist_a_d[0]  = a_dat;
    hist_b_d[0]  = b_dat;
    hist_am_d[0] = a_mrk;
    hist_bm_d[0] = b_mrk;
    for (int i = 1; i < MAXDLY; i++) begin
      hist_a_d[i]  = hist_a_q[i-1];
      hist_b_d[i]  = hist_b_q[i-1];
      hist_am_d[i] = hist_am_q[i-1];
      hist_bm_d[i] = hist_bm_q[i-1];
    end

    // While counting, the running count is the skew that a lag marker in
    // this cycle would lock to, so the lock edge already uses it.
    case (state_q)
      LOCKED:  sel_skew = skew_q;
      COUNT:   sel_skew = cnt_q;
      default: sel_skew = '0;
    endcase

    al_a  = lead_b_q ? a_dat : pick_word(hist_a_q, a_dat, sel_skew);
    al_b  = lead_b_q ? pick_word(hist_b_q, b_dat, sel_skew) : b_dat;
    al_am = lead_b_q ? a_mrk : pick_bit(hist_am_q, a_mrk, sel_skew);
    al_bm = lead_b_q ? pick_bit(hist_bm_q, b_mrk, sel_skew) : b_mrk;

    lag_mrk  = lead_b_q ? a_mrk : b_mrk;
    lead_mrk = lead_b_q ? b_mrk : a_mrk;

    state_d    = state_q;
    cnt_d      = cnt_q;
    skew_d     = skew_q;
    lead_b_d   = lead_b_q;
    err_d      = err_q;
    out_vld_d  = out_vld_q;
    out_mrk_d  = 1'b0;
    out_a_d    = out_a_q;
    out_b_d    = out_b_q;
    lock_now   = 1'b0;
    relock_now = 1'b0;

    case (state_q)
      SEARCH: begin
        out_vld_d = 1'b0;
        if (a_mrk && b_mrk) begin
          skew_d   = '0;
          lead_b_d = 1'b0;
          lock_now = 1'b1;
        end else if (a_mrk || b_mrk) begin
          lead_b_d = b_mrk;
          cnt_d    = SKW_W'(1);
          state_d  = COUNT;
        end
      end
      COUNT: begin
        // A lag marker wins even if the lead lane marks in the same cycle.
        if (lag_mrk) begin
          skew_d   = cnt_q;
          lock_now = 1'b1;
        end else if (lead_mrk || int'(cnt_q) == MAXDLY) begin
          err_d   = 1'b1;
          state_d = SEARCH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LOCKED: begin
        out_a_d   = al_a;
        out_b_d   = al_b;
        out_mrk_d = al_am & al_bm;
        if (al_am ^ al_bm) begin
          err_d      = 1'b1;
          out_vld_d  = 1'b0;
          state_d    = SEARCH;
          relock_now = 1'b1;
        end
      end
      default: state_d = SEARCH;
    endcase

    if (lock_now) begin
      state_d   = LOCKED;
      out_vld_d = 1'b1;
      out_mrk_d = 1'b1;
      out_a_d   = al_a;
      out_b_d   = al_b;
    end

`ifdef LANE_DESKEW_STATS_EN
    lock_cnt_d   = (lock_now && lock_cnt_q != 8'hFF) ? lock_cnt_q + 8'd1 : lock_cnt_q;
    relock_cnt_d = (relock_now && relock_cnt_q != 8'hFF) ? relock_cnt_q + 8'd1 : relock_cnt_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SEARCH;
      cnt_q     <= '0;
      skew_q    <= '0;
      lead_b_q  <= 1'b0;
      err_q     <= 1'b0;
      out_vld_q <= 1'b0;
      out_mrk_q <= 1'b0;
      out_a_q   <= '0;
      out_b_q   <= '0;
      hist_a_q  <= '0;
      hist_b_q  <= '0;
      hist_am_q <= '0;
      hist_bm_q <= '0;
`ifdef LANE_DESKEW_STATS_EN
      lock_cnt_q   <= '0;
      relock_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      skew_q    <= skew_d;
      lead_b_q  <= lead_b_d;
      err_q     <= err_d;
      out_vld_q <= out_vld_d;
      out_mrk_q <= out_mrk_d;
      out_a_q   <= out_a_d;
      out_b_q   <= out_b_d;
      hist_a_q  <= hist_a_d;
      hist_b_q  <= hist_b_d;
      hist_am_q <= hist_am_d;
      hist_bm_q <= hist_bm_d;
`ifdef LANE_DESKEW_STATS_EN
      lock_cnt_q   <= lock_cnt_d;
      relock_cnt_q <= relock_cnt_d;
`endif
    end
  end

  assign out_vld = out_vld_q;
  assign out_a   = out_a_q;
  assign out_b   = out_b_q;
  assign out_mrk = out_mrk_q;
  assign skew    = skew_q;
  assign lead_b  = lead_b_q;
  assign err     = err_q;
`ifdef LANE_DESKEW_STATS_EN
  assign lock_cnt   = lock_cnt_q;
  assign relock_cnt = relock_cnt_q;
`endif

endmodule
